// File: rtl/crc_pkg.sv
// crc_pkg: shared CRC widths, generator polynomial and x^p mod POLY helper.
package crc_pkg;
  localparam int DEF_BW = 4;
  localparam int DEF_CRC_BW = 3;
  localparam logic [DEF_CRC_BW:0] DEF_POLY = 4'b1011;
  function automatic logic [31:0] xp_mod(input int p, input int cbw, input logic [31:0] poly);
    logic [31:0] r;
    r = 32'd1;
    for (int k = 0; k < p; k++) begin
      r = r << 1;
      if (r[cbw]) r = r ^ poly;
    end
    return r & ((32'd1 << cbw) - 32'd1);
  endfunction
endpackage

// File: rtl/crc_syndrome.sv
// crc_syndrome: combinational remainder of a codeword modulo the generator polynomial.
module crc_syndrome
  import crc_pkg::*;
#(
  parameter int BW = DEF_BW,
  parameter int CRC_BW = DEF_CRC_BW,
  parameter logic [CRC_BW:0] POLY = DEF_POLY
) (
  input  logic [BW+CRC_BW-1:0] i_cw,
  output logic [CRC_BW-1:0]    o_syn
);
  localparam int N = BW + CRC_BW;
  logic [CRC_BW-1:0] w_col [N];
  for (genvar i = 0; i < N; i++) begin : g_col
    assign w_col[i] = CRC_BW'(xp_mod(i, CRC_BW, 32'(POLY)));
  end
  // The remainder is linear in the codeword bits: XOR the columns of set bits.
  always_comb begin
    o_syn = '0;
    for (int i = 0; i < N; i++) o_syn = o_syn ^ (i_cw[i] ? w_col[i] : '0);
  end
endmodule

// File: rtl/receiver.sv
// receiver: single-error-correcting CRC decoder with a registered data output.
module receiver
  import crc_pkg::*;
#(
  parameter int BW = DEF_BW,
  parameter int CRC_BW = DEF_CRC_BW,
  parameter logic [CRC_BW:0] POLY = DEF_POLY
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [BW+CRC_BW-1:0] in,
  output logic [BW-1:0]        out
);
  localparam int N = BW + CRC_BW;
  logic [CRC_BW-1:0] w_syn;
  logic [CRC_BW-1:0] w_col [N];
  logic [BW-1:0]     w_flip;
  logic              w_found;
  logic [BW-1:0]     r_out;
  crc_syndrome #(.BW(BW), .CRC_BW(CRC_BW), .POLY(POLY)) u_syn (.i_cw(in), .o_syn(w_syn));
  for (genvar i = 0; i < N; i++) begin : g_col
    assign w_col[i] = CRC_BW'(xp_mod(i, CRC_BW, 32'(POLY)));
  end
  // Lowest matching position wins; a CRC-bit match consumes the error without touching data.
  always_comb begin
    w_flip = '0;
    w_found = (w_syn == '0);
    for (int i = 0; i < CRC_BW; i++) if (w_syn == w_col[i]) w_found = 1'b1;
    for (int j = 0; j < BW; j++)
      if (!w_found && w_syn == w_col[j+CRC_BW]) begin
        w_flip[j] = 1'b1;
        w_found = 1'b1;
      end
  end
  always_ff @(posedge clk) r_out <= rstn ? '0 : in[N-1:CRC_BW] ^ w_flip;
  assign out = r_out;
endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed and randomized checks of the CRC single-error-correcting receiver.
module tb_receiver;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [6:0] cw = '0;
  logic [3:0] dout;
  int tests = 0;
  int fails = 0;
  receiver dut (.clk(clk), .rstn(rstn), .in(cw), .out(dout));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [2:0] poly_mod(input logic [6:0] v);
    logic [6:0] r;
    logic [6:0] g;
    r = v;
    g = 7'b0001011;
    for (int b = 6; b >= 3; b--) if (r[b]) r = r ^ (g << (b - 3));
    return r[2:0];
  endfunction
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] s;
    s = {d, 3'b000};
    return {d, poly_mod(s)};
  endfunction
  task automatic test_reset();
    rstn = 1'b1;
    cw = 7'h7F;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (dout !== 4'h0) begin
        fails++;
        $display("FAIL reset edge%0d: out=%h expected=0", i, dout);
      end
    end
    rstn = 1'b0;
  endtask
  task automatic test_clean();
    logic [6:0] v [4] = '{7'h00, 7'h0B, 7'h45, 7'h7F};
    logic [3:0] e [4] = '{4'h0, 4'h1, 4'h8, 4'hF};
    logic [3:0] prev;
    prev = dout;
    for (int i = 0; i < 4; i++) begin
      cw = v[i];
      #2;
      tests++;
      if (dout !== prev) begin
        fails++;
        $display("FAIL clean_hold %h: out=%h expected=%h", v[i], dout, prev);
      end
      tick();
      tests++;
      if (dout !== e[i]) begin
        fails++;
        $display("FAIL clean %h: out=%h expected=%h", v[i], dout, e[i]);
      end
      prev = e[i];
    end
  endtask
  task automatic test_data_err();
    logic [6:0] v [2] = '{7'h4B, 7'h4D};
    logic [3:0] e [2] = '{4'h1, 4'h8};
    for (int i = 0; i < 2; i++) begin
      cw = v[i];
      tick();
      tests++;
      if (dout !== e[i]) begin
        fails++;
        $display("FAIL data_err %h: out=%h expected=%h", v[i], dout, e[i]);
      end
    end
  endtask
  task automatic test_crc_err();
    logic [6:0] v [2] = '{7'h44, 7'h7B};
    logic [3:0] e [2] = '{4'h8, 4'hF};
    for (int i = 0; i < 2; i++) begin
      cw = v[i];
      tick();
      tests++;
      if (dout !== e[i]) begin
        fails++;
        $display("FAIL crc_err %h: out=%h expected=%h", v[i], dout, e[i]);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] d;
    int f;
    for (int i = 0; i < 100; i++) begin
      if (i == 50) begin
        rstn = 1'b1;
        cw = 7'($urandom);
        tick();
        tests++;
        if (dout !== 4'h0) begin
          fails++;
          $display("FAIL midstream_reset: out=%h expected=0", dout);
        end
        rstn = 1'b0;
      end
      d = 4'($urandom_range(0, 15));
      f = $urandom_range(0, 7);
      cw = encode(d) ^ ((f < 7) ? (7'd1 << f) : 7'd0);
      tick();
      tests++;
      if (dout !== d) begin
        fails++;
        $display("FAIL stream[%0d] in=%h flip=%0d: out=%h expected=%h", i, cw, f, dout, d);
      end
    end
  endtask
  initial begin
    test_reset();
    test_clean();
    test_data_err();
    test_crc_err();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
